bridge_router: RTL and testbench
================================

BRIDGE_ROUTER -- requirements
Module: bridge_router

Interface
REQ-001 SHALL have parameter NUM_LEAVES, default 6, number of downstream leaves (1..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, bridge address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, bridge data width.
REQ-004 SHALL have parameter FROM_ADDR[NUM_LEAVES], default all 0, inclusive lower bound per leaf.
REQ-005 SHALL have parameter TO_ADDR[NUM_LEAVES], default all 0, inclusive upper bound per leaf.
REQ-006 SHALL have parameter RELATIVE[NUM_LEAVES] bit mask, default 0; when a bit is set, that leaf receives its address minus its FROM_ADDR.
REQ-007 SHALL have parameter TIMEOUT, default 16, cycles to wait for read data (1..255).
REQ-008 SHALL have parameter DEFAULT_DATA, default 32'hDEADBEEF, returned on an unmapped or timed-out read.
REQ-009 SHALL use one clock and an asynchronous active-low reset: clk_74a input 1, bridge clock; reset_n input 1, asynchronous active-low reset.
REQ-010 SHALL have the following upstream ports:
- addr input ADDR_WIDTH, request address.
- wr input 1, single-cycle write strobe.
- rd input 1, single-cycle read strobe.
- wr_data input DATA_WIDTH, write data.
- rd_data output DATA_WIDTH, read data, held until next read completes.
REQ-011 SHALL have the following leaf ports:
- leaf_addr output ADDR_WIDTH, shared leaf address.
- leaf_wr_data output DATA_WIDTH, shared write data.
- leaf_wr output NUM_LEAVES, one-hot write strobe.
- leaf_rd output NUM_LEAVES, one-hot read strobe.
- leaf_rd_valid input NUM_LEAVES, per-leaf read-data-valid pulse.
- leaf_rd_data input NUM_LEAVES x DATA_WIDTH, per-leaf read data.
REQ-012 SHALL have the following status ports:
- rd_busy output 1, read outstanding.
- err_timeout output 1, single-cycle pulse on read timeout.
- miss_count output 16, saturating count of unmapped accesses.

Function
REQ-013 SHALL decode by inclusive compare FROM_ADDR[i] <= addr <= TO_ADDR[i]; on overlap the lowest index SHALL win; no match is a miss.
REQ-014 SHALL register requests: leaf_wr/leaf_rd SHALL pulse exactly one cycle, exactly 1 cycle after the upstream strobe, with leaf_addr/leaf_wr_data registered in the same cycle.
REQ-015 SHALL hold leaf_addr and leaf_wr_data stable until the next accepted request.
REQ-016 SHALL compute relative addresses modulo 2^ADDR_WIDTH; non-relative leaves get addr unchanged.
REQ-017 SHALL, when wr and rd are asserted in the same cycle, execute the write only, drop the read, and increment miss_count.
REQ-018 SHALL, on a write miss, assert no leaf_wr and increment miss_count.
REQ-019 SHALL implement a read FSM with states IDLE, WAIT, DONE.
- IDLE, mapped rd: go to WAIT, rd_busy=1, timeout counter loaded with TIMEOUT.
- IDLE, unmapped rd: go to DONE; rd_data=DEFAULT_DATA 1 cycle after rd; miss_count increments.
- WAIT: capture leaf_rd_data[sel] into rd_data when leaf_rd_valid[sel]=1, then go to DONE.
- WAIT: decrement counter each cycle without valid; at 0, rd_data=DEFAULT_DATA, err_timeout pulses 1 cycle, go to DONE.
- DONE: rd_busy=0; return to IDLE next cycle.
REQ-020 SHALL count the timeout from the cycle leaf_rd is asserted; valid arriving in the same cycle the counter reaches 0 SHALL win over the timeout.
REQ-021 SHALL ignore leaf_rd_valid from non-selected leaves and any valid while in IDLE or DONE.
REQ-022 SHALL abort the outstanding read on a new rd in WAIT or DONE and restart at the new address without updating rd_data.
REQ-023 SHALL forward a wr in WAIT normally without disturbing the outstanding read.
REQ-024 SHALL saturate miss_count at 16'hFFFF.

Reset
REQ-025 SHALL, when reset_n=0, asynchronously clear the FSM to IDLE and drive:
- rd_data=0, leaf_addr=0, leaf_wr_data=0.
- leaf_wr=0, leaf_rd=0.
- rd_busy=0, err_timeout=0, miss_count=0.
REQ-026 SHALL deassert reset synchronously to clk_74a; a read in flight at reset SHALL be discarded and its late valid ignored.

Verification
REQ-027 Ranges {f8000000-f8001fff, f8002000-f80020ff}, RELATIVE=2'b10; wr to f8002010 -> leaf_wr=2'b10 one cycle later, leaf_addr=0x10.
REQ-028 rd f8000004; leaf 0 valid 3 cycles later with 0x12345678 -> rd_data=0x12345678, rd_busy high exactly 3 cycles.
REQ-029 rd f8000000 with no valid, TIMEOUT=4 -> err_timeout pulse 4 cycles after leaf_rd, rd_data=DEADBEEF.
REQ-030 rd 0x00200000 (unmapped) -> no leaf strobe, rd_data=DEADBEEF next cycle, miss_count=1.
REQ-031 Simultaneous wr+rd, then overlapping ranges 0-ff and 80-1ff with access to 0x90 -> write only and miss_count+1; leaf 0 selected.
REQ-032 reset_n low during WAIT, then leaf valid -> all outputs 0, FSM IDLE, rd_data stays 0.

Source files
------------

// File: rtl/bridge_router.sv
// bridge_router: address-decoding bridge fan-out to NUM_LEAVES leaves with registered strobes and read timeout
module bridge_router #(
    parameter int NUM_LEAVES = 6,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [NUM_LEAVES-1:0][ADDR_WIDTH-1:0] FROM_ADDR = '0,
    parameter logic [NUM_LEAVES-1:0][ADDR_WIDTH-1:0] TO_ADDR = '0,
    parameter logic [NUM_LEAVES-1:0] RELATIVE = '0,
    parameter int TIMEOUT = 16,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_DATA = 32'hDEADBEEF
) (
    input  logic                                 clk_74a,
    input  logic                                 reset_n,
    input  logic [ADDR_WIDTH-1:0]                addr,
    input  logic                                 wr,
    input  logic                                 rd,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic [ADDR_WIDTH-1:0]                leaf_addr,
    output logic [DATA_WIDTH-1:0]                leaf_wr_data,
    output logic [NUM_LEAVES-1:0]                leaf_wr,
    output logic [NUM_LEAVES-1:0]                leaf_rd,
    input  logic [NUM_LEAVES-1:0]                leaf_rd_valid,
    input  logic [NUM_LEAVES-1:0][DATA_WIDTH-1:0] leaf_rd_data,
    output logic                                 rd_busy,
    output logic                                 err_timeout,
    output logic [15:0]                          miss_count
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  state;
    logic [NUM_LEAVES-1:0]   hit_oh;
    logic [NUM_LEAVES-1:0]   sel_oh;
    logic [ADDR_WIDTH-1:0]   map_addr;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_valid;
    logic                    hit;
    logic [7:0]              cnt;

    assign hit = |hit_oh;
    assign sel_valid = |(leaf_rd_valid & sel_oh);

    // Decode the request; walking downward lets the lowest matching leaf win on overlap
    always_comb begin
        hit_oh = '0;
        map_addr = addr;
        for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
            if (addr >= FROM_ADDR[i] && addr <= TO_ADDR[i]) begin
                hit_oh = '0;
                hit_oh[i] = 1'b1;
                map_addr = RELATIVE[i] ? addr - FROM_ADDR[i] : addr;
            end
        end
    end

    // Pick the read data of the leaf the outstanding read was sent to
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_LEAVES; i++)
            if (sel_oh[i]) sel_data = leaf_rd_data[i];
    end

    // Request registration, miss counting and the read FSM; a new rd always restarts the read path
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rd_data <= '0;
            leaf_addr <= '0;
            leaf_wr_data <= '0;
            leaf_wr <= '0;
            leaf_rd <= '0;
            sel_oh <= '0;
            cnt <= '0;
            rd_busy <= 1'b0;
            err_timeout <= 1'b0;
            miss_count <= '0;
        end else begin
            leaf_wr <= '0;
            leaf_rd <= '0;
            err_timeout <= 1'b0;
            if ((wr || rd) && (!hit || (wr && rd)) && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
            if (wr && hit) begin
                leaf_wr <= hit_oh;
                leaf_addr <= map_addr;
                leaf_wr_data <= wr_data;
            end
            if (rd && !wr) begin
                if (hit) begin
                    leaf_rd <= hit_oh;
                    leaf_addr <= map_addr;
                    sel_oh <= hit_oh;
                    cnt <= 8'(TIMEOUT);
                    rd_busy <= 1'b1;
                    state <= WAIT;
                end else begin
                    rd_data <= DEFAULT_DATA;
                    rd_busy <= 1'b0;
                    state <= DONE;
                end
            end else begin
                case (state)
                    WAIT: begin
                        if (sel_valid) begin
                            rd_data <= sel_data;
                            rd_busy <= 1'b0;
                            state <= DONE;
                        end else if (cnt == 8'd1) begin
                            rd_data <= DEFAULT_DATA;
                            err_timeout <= 1'b1;
                            rd_busy <= 1'b0;
                            state <= DONE;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bridge_router.sv
// tb_bridge_router: directed checks of decode, strobes, read completion, timeout, misses and reset
module tb_bridge_router;
    logic             clk_74a = 1'b0;
    logic             reset_n = 1'b0;
    logic [31:0]      addr = '0;
    logic             wr = 1'b0;
    logic             rd = 1'b0;
    logic [31:0]      wr_data = '0;
    logic [31:0]      rd_data;
    logic [31:0]      leaf_addr;
    logic [31:0]      leaf_wr_data;
    logic [3:0]       leaf_wr;
    logic [3:0]       leaf_rd;
    logic [3:0]       leaf_rd_valid = '0;
    logic [3:0][31:0] leaf_rd_data = '0;
    logic             rd_busy;
    logic             err_timeout;
    logic [15:0]      miss_count;
    int               checks = 0;
    int               failures = 0;
    int               busy_cycles;

    bridge_router #(
        .NUM_LEAVES(4),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .FROM_ADDR({32'h80, 32'h0, 32'hf8002000, 32'hf8000000}),
        .TO_ADDR({32'h1ff, 32'hff, 32'hf80020ff, 32'hf8001fff}),
        .RELATIVE(4'b0010),
        .TIMEOUT(4),
        .DEFAULT_DATA(32'hDEADBEEF)
    ) dut (
        .clk_74a(clk_74a),
        .reset_n(reset_n),
        .addr(addr),
        .wr(wr),
        .rd(rd),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .leaf_addr(leaf_addr),
        .leaf_wr_data(leaf_wr_data),
        .leaf_wr(leaf_wr),
        .leaf_rd(leaf_rd),
        .leaf_rd_valid(leaf_rd_valid),
        .leaf_rd_data(leaf_rd_data),
        .rd_busy(rd_busy),
        .err_timeout(err_timeout),
        .miss_count(miss_count)
    );

    always #5 clk_74a = ~clk_74a;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_74a);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_leaf_addr", leaf_addr, 32'h0);
        chk("rst_leaf_wr_data", leaf_wr_data, 32'h0);
        chk("rst_leaf_wr", 32'(leaf_wr), 32'h0);
        chk("rst_leaf_rd", 32'(leaf_rd), 32'h0);
        chk("rst_busy", 32'(rd_busy), 32'h0);
        chk("rst_timeout", 32'(err_timeout), 32'h0);
        chk("rst_miss", 32'(miss_count), 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // relative write to leaf 1
        addr = 32'hf8002010; wr = 1'b1; wr_data = 32'hA5A5A5A5;
        tick();
        wr = 1'b0;
        chk("wr_leaf_wr", 32'(leaf_wr), 32'h2);
        chk("wr_leaf_addr", leaf_addr, 32'h10);
        chk("wr_leaf_data", leaf_wr_data, 32'hA5A5A5A5);
        chk("wr_no_rd", 32'(leaf_rd), 32'h0);
        tick();
        chk("wr_pulse_end", 32'(leaf_wr), 32'h0);
        chk("wr_addr_hold", leaf_addr, 32'h10);

        // read leaf 0, valid sampled 3 edges after rd; stray valid from leaf 1 ignored
        addr = 32'hf8000004; rd = 1'b1;
        tick();
        rd = 1'b0;
        busy_cycles = 0;
        chk("rd_leaf_rd", 32'(leaf_rd), 32'h1);
        chk("rd_leaf_addr", leaf_addr, 32'hf8000004);
        busy_cycles += int'(rd_busy);
        leaf_rd_valid = 4'b0010; leaf_rd_data[1] = 32'hBADBAD00;
        tick();
        leaf_rd_valid = '0;
        chk("rd_strobe_end", 32'(leaf_rd), 32'h0);
        busy_cycles += int'(rd_busy);
        tick();
        busy_cycles += int'(rd_busy);
        leaf_rd_valid = 4'b0001; leaf_rd_data[0] = 32'h12345678;
        tick();
        leaf_rd_valid = '0;
        busy_cycles += int'(rd_busy);
        chk("rd_data", rd_data, 32'h12345678);
        chk("rd_busy_cycles", 32'(busy_cycles), 32'd3);
        tick();

        // unmapped read
        addr = 32'h00200000; rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("miss_no_strobe", 32'(leaf_rd), 32'h0);
        chk("miss_rd_data", rd_data, 32'hDEADBEEF);
        chk("miss_count1", 32'(miss_count), 32'd1);
        chk("miss_busy", 32'(rd_busy), 32'h0);
        tick();

        // valid on the final timeout cycle wins
        addr = 32'hf8000000; rd = 1'b1;
        tick();
        rd = 1'b0;
        tick();
        tick();
        tick();
        leaf_rd_valid = 4'b0001; leaf_rd_data[0] = 32'hCAFEF00D;
        tick();
        leaf_rd_valid = '0;
        chk("edge_rd_data", rd_data, 32'hCAFEF00D);
        chk("edge_no_timeout", 32'(err_timeout), 32'h0);
        tick();

        // timeout with no valid
        addr = 32'hf8000000; rd = 1'b1;
        tick();
        rd = 1'b0;
        tick();
        tick();
        tick();
        chk("to_not_yet", 32'(err_timeout), 32'h0);
        chk("to_busy", 32'(rd_busy), 32'h1);
        tick();
        chk("to_pulse", 32'(err_timeout), 32'h1);
        chk("to_rd_data", rd_data, 32'hDEADBEEF);
        chk("to_busy_clr", 32'(rd_busy), 32'h0);
        tick();
        chk("to_pulse_end", 32'(err_timeout), 32'h0);

        // simultaneous wr+rd to overlapping region: lowest index leaf 2 written, read dropped
        addr = 32'h90; wr = 1'b1; rd = 1'b1; wr_data = 32'h77;
        tick();
        wr = 1'b0; rd = 1'b0;
        chk("wrrd_leaf_wr", 32'(leaf_wr), 32'h4);
        chk("wrrd_leaf_rd", 32'(leaf_rd), 32'h0);
        chk("wrrd_addr", leaf_addr, 32'h90);
        chk("wrrd_miss", 32'(miss_count), 32'd2);
        chk("wrrd_busy", 32'(rd_busy), 32'h0);
        tick();

        // write miss
        addr = 32'h00300000; wr = 1'b1;
        tick();
        wr = 1'b0;
        chk("wmiss_leaf_wr", 32'(leaf_wr), 32'h0);
        chk("wmiss_count", 32'(miss_count), 32'd3);
        chk("wmiss_addr_hold", leaf_addr, 32'h90);

        // abort in WAIT, restart at leaf 1; old leaf valid ignored
        addr = 32'hf8000000; rd = 1'b1;
        tick();
        addr = 32'hf8002004;
        tick();
        rd = 1'b0;
        chk("abort_leaf_rd", 32'(leaf_rd), 32'h2);
        chk("abort_addr", leaf_addr, 32'h4);
        chk("abort_rd_data", rd_data, 32'hDEADBEEF);
        leaf_rd_valid = 4'b0001; leaf_rd_data[0] = 32'h00000BAD;
        tick();
        chk("abort_ignore", rd_data, 32'hDEADBEEF);
        chk("abort_busy", 32'(rd_busy), 32'h1);
        // write during WAIT forwarded without disturbing the read
        leaf_rd_valid = '0;
        addr = 32'h10; wr = 1'b1; wr_data = 32'h99;
        tick();
        wr = 1'b0;
        chk("wait_wr", 32'(leaf_wr), 32'h4);
        chk("wait_wr_busy", 32'(rd_busy), 32'h1);
        leaf_rd_valid = 4'b0010; leaf_rd_data[1] = 32'h11112222;
        tick();
        leaf_rd_valid = '0;
        chk("abort_new_data", rd_data, 32'h11112222);
        chk("abort_done", 32'(rd_busy), 32'h0);
        tick();

        // reset during WAIT; late valid ignored
        addr = 32'hf8000000; rd = 1'b1;
        tick();
        rd = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("arst_rd_data", rd_data, 32'h0);
        chk("arst_leaf_rd", 32'(leaf_rd), 32'h0);
        chk("arst_leaf_addr", leaf_addr, 32'h0);
        chk("arst_busy", 32'(rd_busy), 32'h0);
        chk("arst_miss", 32'(miss_count), 32'h0);
        tick();
        reset_n = 1'b1;
        leaf_rd_valid = 4'b0001; leaf_rd_data[0] = 32'h55555555;
        tick();
        leaf_rd_valid = '0;
        tick();
        chk("arst_late_valid", rd_data, 32'h0);
        chk("arst_busy_after", 32'(rd_busy), 32'h0);
        chk("arst_timeout", 32'(err_timeout), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
